// File: rtl/ifft8_if.sv
// Streaming handshake bundle for the 8-point sequential IFFT.
// Bins enter on the in_* side, time samples leave on the out_* side.
interface ifft8_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] xr;
  logic [7:0] xi;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] yr;
  logic [7:0] yi;
  logic [2:0] out_idx;

  modport slave (
    input  in_valid, xr, xi, out_ready,
    output in_ready, out_valid, yr, yi, out_idx
  );

  modport master (
    output in_valid, xr, xi, out_ready,
    input  in_ready, out_valid, yr, yi, out_idx
  );
endinterface

// File: rtl/ifft8_seq.sv
// Sequential 8-point inverse FFT: bit-reversed load, one radix-2
// DIT butterfly per cycle in place, then natural-order unload.
module ifft8_seq (
  input  logic   clk,
  input  logic   rst,
  ifft8_if.slave bus
);
  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    UNLOAD
  } state_t;

  state_t st;
  logic [2:0] ld_cnt;
  logic [3:0] bf_cnt;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] yr;
  logic [7:0] yi;
  logic [2:0] out_idx;

  logic signed [11:0] mr [8];
  logic signed [11:0] mi [8];

  logic [1:0] stg;
  logic [1:0] bfly;
  logic [2:0] top;
  logic [2:0] bot;
  logic [1:0] tw;
  logic signed [9:0] wr;
  logic signed [9:0] wi;
  logic signed [11:0] ar;
  logic signed [11:0] ai;
  logic signed [11:0] br;
  logic signed [11:0] bi;
  logic signed [22:0] pr;
  logic signed [22:0] pi;
  logic signed [11:0] tr;
  logic signed [11:0] ti;
  logic [2:0] nxt;
  logic [2:0] ld_addr;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.yr        = yr;
  assign bus.yi        = yi;
  assign bus.out_idx   = out_idx;

  assign stg     = bf_cnt[3:2];
  assign bfly    = bf_cnt[1:0];
  assign nxt     = out_idx + 3'd1;
  assign ld_addr = {ld_cnt[0], ld_cnt[1], ld_cnt[2]};

  // Pair addresses and twiddle exponent for stage stg, butterfly bfly.
  always_comb begin
    top = '0;
    bot = '0;
    tw  = '0;
    unique case (stg)
      2'd0: begin
        top = {bfly, 1'b0};
        bot = {bfly, 1'b1};
        tw  = 2'd0;
      end
      2'd1: begin
        top = {bfly[1], 1'b0, bfly[0]};
        bot = {bfly[1], 1'b1, bfly[0]};
        tw  = {bfly[0], 1'b0};
      end
      default: begin
        top = {1'b0, bfly};
        bot = {1'b1, bfly};
        tw  = bfly;
      end
    endcase
  end

  always_comb begin
    wr = 10'sd256;
    wi = 10'sd0;
    unique case (tw)
      2'd0: begin wr = 10'sd256;  wi = 10'sd0;   end
      2'd1: begin wr = 10'sd181;  wi = 10'sd181; end
      2'd2: begin wr = 10'sd0;    wi = 10'sd256; end
      default: begin
        wr = -10'sd181;
        wi = 10'sd181;
      end
    endcase
  end

  assign ar = mr[top];
  assign ai = mi[top];
  assign br = mr[bot];
  assign bi = mi[bot];

  assign pr = 23'(br) * 23'(wr) - 23'(bi) * 23'(wi);
  assign pi = 23'(br) * 23'(wi) + 23'(bi) * 23'(wr);

  assign tr = (tw == 2'd0) ? br : 12'(pr >>> 8);
  assign ti = (tw == 2'd0) ? bi : 12'(pi >>> 8);

  function automatic logic [7:0] sat8(input logic signed [11:0] v);
    logic signed [8:0] s;
    s = 9'(v >>> 3);
    if (s > 9'sd127) return 8'h7f;
    if (s < -9'sd128) return 8'h80;
    return s[7:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= LOAD;
      ld_cnt    <= '0;
      bf_cnt    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      yr        <= '0;
      yi        <= '0;
      out_idx   <= '0;
    end else begin
      unique case (st)
        LOAD: begin
          if (bus.in_valid) begin
            mr[ld_addr] <= {{4{bus.xr[7]}}, bus.xr};
            mi[ld_addr] <= {{4{bus.xi[7]}}, bus.xi};
            ld_cnt      <= ld_cnt + 3'd1;
            if (ld_cnt == 3'd7) begin
              st       <= COMPUTE;
              in_ready <= 1'b0;
              bf_cnt   <= '0;
            end
          end
        end
        COMPUTE: begin
          mr[top] <= ar + tr;
          mi[top] <= ai + ti;
          mr[bot] <= ar - tr;
          mi[bot] <= ai - ti;
          bf_cnt  <= bf_cnt + 4'd1;
          // Address 0 is final after the first stage-2 butterfly.
          if (bf_cnt == 4'd11) begin
            st        <= UNLOAD;
            out_valid <= 1'b1;
            out_idx   <= '0;
            yr        <= sat8(mr[0]);
            yi        <= sat8(mi[0]);
          end
        end
        UNLOAD: begin
          if (bus.out_ready) begin
            if (out_idx == 3'd7) begin
              st        <= LOAD;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              ld_cnt    <= '0;
              out_idx   <= '0;
            end else begin
              out_idx <= nxt;
              yr      <= sat8(mr[nxt]);
              yi      <= sat8(mi[nxt]);
            end
          end
        end
        default: begin
          st        <= LOAD;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ifft8_seq.sv
// Scoreboard bench for ifft8_seq: directed frames with hand-worked
// results, backpressure, mid-unload reset and random model frames.
module tb_ifft8_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifft8_if bus ();

  ifft8_seq dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] i;
    logic [2:0] n;
  } smp_t;

  typedef logic [7:0] vec_t [8];
  typedef smp_t exp_t [8];

  smp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit rdy_rand = 1'b0;
  bit rdy_hold = 1'b1;
  bit thru_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_hold;
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic smp_t mk(input int r, input int i, input int n);
    return {8'(r), 8'(i), 3'(n)};
  endfunction

  function automatic int rev3(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  function automatic int wrap12(input int v);
    int w;
    w = v & 32'hfff;
    if (w >= 2048) w -= 4096;
    return w;
  endfunction

  function automatic int sat(input int v);
    int s;
    s = v >>> 3;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  function automatic exp_t model(input vec_t fr, input vec_t fi);
    int re[8];
    int im[8];
    int wre[4];
    int wim[4];
    int h, m, p, q, tr, ti, a_r, a_i;
    exp_t ex;
    wre = '{256, 181, 0, -181};
    wim = '{0, 181, 256, 181};
    for (int k = 0; k < 8; k++) begin
      re[rev3(k)] = int'($signed(fr[k]));
      im[rev3(k)] = int'($signed(fi[k]));
    end
    for (int s = 0; s < 3; s++) begin
      h = 1 << s;
      for (int g = 0; g < 8; g += 2 * h) begin
        for (int j = 0; j < h; j++) begin
          m = j * (4 >> s);
          p = g + j;
          q = p + h;
          if (m == 0) begin
            tr = re[q];
            ti = im[q];
          end else begin
            tr = (re[q] * wre[m] - im[q] * wim[m]) >>> 8;
            ti = (re[q] * wim[m] + im[q] * wre[m]) >>> 8;
          end
          a_r = re[p];
          a_i = im[p];
          re[p] = wrap12(a_r + tr);
          im[p] = wrap12(a_i + ti);
          re[q] = wrap12(a_r - tr);
          im[q] = wrap12(a_i - ti);
        end
      end
    end
    for (int n = 0; n < 8; n++) ex[n] = mk(sat(re[n]), sat(im[n]), n);
    return ex;
  endfunction

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    smp_t cur;
    smp_t held;
    smp_t e;
    bit stalled;
    int last0;
    stalled = 1'b0;
    last0 = -1;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        cur = {bus.yr, bus.yi, bus.out_idx};
        if (stalled) check("stall_hold", 32'(cur), 32'(held));
        if (bus.out_ready) begin
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got %0h required none", cur);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("out_n%0d", e.n), 32'(cur), 32'(e));
          end
          if (bus.out_idx == 3'd0) begin
            if (thru_chk && last0 >= 0)
              check("frame_period", 32'(cyc - last0), 32'd28);
            last0 = thru_chk ? cyc : -1;
          end
        end else begin
          stalled = 1'b1;
          held = cur;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic send_bin(input logic [7:0] r, input logic [7:0] i,
                          input int gap);
    bit acc;
    int t;
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.xr = r;
    bus.xi = i;
    t = 0;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 400);
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL in_accept_timeout: got no in_ready required accept");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input vec_t fr, input vec_t fi, input exp_t ex,
                            input int gapmax);
    for (int n = 0; n < 8; n++) exp_q.push_back(ex[n]);
    for (int k = 0; k < 8; k++)
      send_bin(fr[k], fi[k], gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check(nm, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vec_t zr, zi, fr, fi;
    exp_t e_imp, e_dc, e_tone, ex;
    int tre[8];
    int tim[8];
    int t;
    tre = '{8, 5, 0, -6, -8, -6, 0, 5};
    tim = '{0, 5, 8, 5, 0, -6, -8, -6};
    for (int n = 0; n < 8; n++) begin
      zr[n] = 8'd0;
      zi[n] = 8'd0;
      e_imp[n] = mk(8, 0, n);
      e_dc[n] = mk(n == 0 ? 8 : 0, 0, n);
      e_tone[n] = mk(tre[n], tim[n], n);
    end

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.xr = '0;
    bus.xi = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_yr", 32'(bus.yr), 32'd0);
    check("rst_yi", 32'(bus.yi), 32'd0);
    check("rst_out_idx", 32'(bus.out_idx), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    fr = zr; fi = zi; fr[0] = 8'd64;
    send_frame(fr, fi, e_imp, 0);
    for (int k = 0; k < 8; k++) fr[k] = 8'd8;
    send_frame(fr, fi, e_dc, 0);
    fr = zr; fr[1] = 8'd64;
    send_frame(fr, fi, e_tone, 0);
    drain("drain_directed");

    rdy_rand = 1'b1;
    send_frame(fr, fi, e_tone, 3);
    send_frame(fr, fi, e_tone, 2);
    drain("drain_backpressure");
    rdy_rand = 1'b0;

    rdy_hold = 1'b0;
    fr = zr; fr[0] = 8'd64;
    send_frame(fr, fi, e_imp, 0);
    t = 0;
    while (exp_q.size() > 5 && t < 200) begin
      if (t == 25) rdy_hold = 1'b1;
      @(posedge clk);
      #2;
      t++;
    end
    check("unload_started", 32'(exp_q.size()), 32'd5);
    rst = 1'b1;
    rdy_hold = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_yr_yi", 32'({bus.yr, bus.yi}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_hold = 1'b1;
    fr = zr; fr[1] = 8'd64;
    send_frame(fr, fi, e_tone, 0);
    drain("drain_after_reset");

    thru_chk = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      for (int k = 0; k < 8; k++) begin
        fr[k] = 8'($urandom);
        fi[k] = 8'($urandom);
      end
      ex = model(fr, fi);
      send_frame(fr, fi, ex, 0);
    end
    drain("drain_random");
    thru_chk = 1'b0;

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ifft8_seq.md
IFFT8_SEQ -- requirements
Module: ifft8_seq

Interface
REQ-001 clk  input  1  rising-edge clock; all state changes on the rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  an input sample is present on xr/xi.
REQ-004 in_ready  output  1  the block accepts a sample this cycle.
REQ-005 xr, xi  input  8 each  spectrum bin real/imag, two's complement.
REQ-006 out_valid  output  1  yr/yi/out_idx hold a valid time-domain sample.
REQ-007 out_ready  input  1  the consumer accepts the output sample this cycle.
REQ-008 yr, yi  output  8 each  time sample real/imag, two's complement.
REQ-009 out_idx  output  3  time index n of the sample on yr/yi.

Function
REQ-010 Computes the 8-point inverse DFT: x[n] = (1/8)·Σ X[k]·e^(+j2πkn/8).
REQ-011 Input bins arrive in natural order k=0..7; a beat is accepted on in_valid&&in_ready.
REQ-012 Accepted bin k is written to working-memory address bitrev3(k): {0,4,2,6,1,5,3,7}.
REQ-013 FSM states: LOAD (in_ready=1, out_valid=0), COMPUTE (both 0), UNLOAD (in_ready=0, out_valid=1).
REQ-014 LOAD->COMPUTE on the cycle the 8th bin is accepted; COMPUTE->UNLOAD after exactly 12 cycles; UNLOAD->LOAD when the n=7 sample is accepted.
REQ-015 COMPUTE executes one radix-2 DIT butterfly per cycle: 3 stages × 4 butterflies, span 1/2/4, in stage-major order.
REQ-016 Twiddles are conjugated (inverse direction) W^-m, m=0..3, in Q8: (256,0), (181,181), (0,256), (-181,181).
REQ-017 Internal data is 12-bit signed; inputs are sign-extended on load.
REQ-018 Twiddle product: both real/imag partial-product pairs are formed at full precision and summed, then the sum is arithmetic-shifted right by 8 (floor); m=0 bypasses the multiply.
REQ-019 Butterfly: a' = a + t, b' = a − t, with t = b·W; results wrap in 12 bits (no intermediate scaling).
REQ-020 Output stage: value arithmetic-shifted right by 3 (floor), then saturated to [-128, 127] independently per component.
REQ-021 UNLOAD presents samples in natural order n=0..7, with out_idx=n.
REQ-022 yr/yi/out_idx hold stable while out_valid=1 && out_ready=0.
REQ-023 out_ready is ignored outside UNLOAD; in_valid is ignored outside LOAD.
REQ-024 in_valid may be deasserted between beats; the load counter advances only on accepted beats.
REQ-025 Latency with continuous valid/ready:
- The first output sample is valid 13 cycles after the cycle the 8th bin is accepted.
- One frame occupies 8 + 12 + 8 = 28 cycles.
REQ-026 in_ready rises on the cycle after the n=7 output is accepted; frames never overlap.

Reset
REQ-027 While rst=1 at a clock edge:
- state goes to LOAD;
- load, butterfly and unload counters go to 0;
- in_ready=1, out_valid=0, yr=0, yi=0, out_idx=0.
REQ-028 rst overrides any in-flight load, compute or unload; the partial frame is discarded, and working-memory contents need not be cleared.
REQ-029 rst has priority over a simultaneous handshake at the same edge.

Verification
REQ-030 Reset: assert rst for 2 cycles in the middle of UNLOAD -> next cycle in_ready=1, out_valid=0, yr=yi=0; a following fresh frame produces correct results.
REQ-031 Impulse: X0=(64,0), all other bins 0 -> every x[n]=(8,0), n=0..7.
REQ-032 DC bins: all Xk=(8,0) -> x0=(8,0), x1..x7=(0,0).
REQ-033 Single tone: X1=(64,0), others 0 -> x0=(8,0), x1=(5,5), x2=(0,8), x3=(-6,5).
REQ-034 Backpressure and gaps:
- gaps in in_valid during load, random out_ready during unload;
- required: results identical to REQ-033, out_idx sequence 0..7 without skips or repeats, and outputs stable while stalled.
REQ-035 Random frames, at least 1000: compare every output against a bit-accurate model of REQ-016..020, and check the 28-cycle frame period under full throughput.
